// File: rtl/qbert_move_ctrl.sv
// Player pyramid-position controller: turns direction requests into one-hot target
// cubes, runs the issue/accept/complete handshake with the sprite layer, tracks visits.
module qbert_move_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_dir_valid,
  input  logic [2:0]  e_dir,
  input  logic        done_move_qb,
  input  logic        e_respawn,
  input  logic        e_restart,
  output logic [27:0] position_qb,
  output logic [27:0] e_next_qb,
  output logic [2:0]  e_jump_qb,
  output logic [27:0] cube_visit,
  output logic [4:0]  visit_cnt,
  output logic        all_visited,
  output logic [15:0] jump_cnt,
  output logic        jump_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {S_READY, S_ISSUE, S_MOVING, S_COMMIT, S_FALLEN} state_t;

  state_t        state_q, state_d;
  logic [27:0]   pos_q, pos_d, next_q, next_d, visit_q, visit_d;
  logic [2:0]    jump_q, jump_d;
  logic [4:0]    vcnt_q, vcnt_d;
  logic [15:0]   jcnt_q, jcnt_d;
  logic          err_q, err_d;
  logic [2:0]    pos_r_q, pos_r_d, pos_c_q, pos_c_d;
  logic [2:0]    tgt_r_q, tgt_r_d, tgt_c_q, tgt_c_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic          dir_ok, tgt_ok;
  logic [2:0]    tr, tc;
  logic [27:0]   tgt_oh;

  function automatic logic [4:0] cube_base(input logic [2:0] r);
    case (r)
      3'd1:    cube_base = 5'd1;
      3'd2:    cube_base = 5'd3;
      3'd3:    cube_base = 5'd6;
      3'd4:    cube_base = 5'd10;
      3'd5:    cube_base = 5'd15;
      3'd6:    cube_base = 5'd21;
      default: cube_base = 5'd0;
    endcase
  endfunction

  // Target cube from the current (row, col); column 0 is the right edge.
  always_comb begin
    tr     = pos_r_q;
    tc     = pos_c_q;
    tgt_ok = 1'b0;
    dir_ok = 1'b1;
    case (e_dir)
      3'b001: begin tr = pos_r_q + 3'd1; tgt_ok = (pos_r_q != 3'd6); end
      3'b010: begin tr = pos_r_q + 3'd1; tc = pos_c_q + 3'd1; tgt_ok = (pos_r_q != 3'd6); end
      3'b011: begin
        tr = pos_r_q - 3'd1; tc = pos_c_q - 3'd1;
        tgt_ok = (pos_r_q != 3'd0) && (pos_c_q != 3'd0);
      end
      3'b100: begin tr = pos_r_q - 3'd1; tgt_ok = (pos_r_q != 3'd0) && (pos_c_q != pos_r_q); end
      default: dir_ok = 1'b0;
    endcase
    tgt_oh = tgt_ok ? (28'h1 << (cube_base(tr) + 5'(tc))) : 28'h0;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    next_d  = next_q;
    jump_d  = jump_q;
    visit_d = visit_q;
    vcnt_d  = vcnt_q;
    jcnt_d  = jcnt_q;
    err_d   = 1'b0;
    pos_r_d = pos_r_q;
    pos_c_d = pos_c_q;
    tgt_r_d = tgt_r_q;
    tgt_c_d = tgt_c_q;
    tmo_d   = tmo_q;
    if (e_restart) begin
      state_d = S_READY;
      pos_d   = 28'h1;
      next_d  = 28'h1;
      jump_d  = 3'd0;
      visit_d = 28'h1;
      vcnt_d  = 5'd1;
      jcnt_d  = 16'd0;
      pos_r_d = 3'd0;
      pos_c_d = 3'd0;
      tgt_r_d = 3'd0;
      tgt_c_d = 3'd0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_READY: begin
          if (e_respawn) begin
            pos_d   = 28'h1;
            next_d  = 28'h1;
            pos_r_d = 3'd0;
            pos_c_d = 3'd0;
          end else if (e_dir_valid && dir_ok && done_move_qb) begin
            next_d  = tgt_oh;
            jump_d  = e_dir;
            tgt_r_d = tr;
            tgt_c_d = tc;
            tmo_d   = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Acceptance is checked first so it wins over a coincident timeout.
          if (!done_move_qb) begin
            jump_d  = 3'd0;
            state_d = S_MOVING;
          end else if (tmo_q == CW'(TIMEOUT - 1)) begin
            next_d  = pos_q;
            jump_d  = 3'd0;
            err_d   = 1'b1;
            state_d = S_READY;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_MOVING: begin
          if (done_move_qb) state_d = S_COMMIT;
        end
        S_COMMIT: begin
          pos_d = next_q;
          if (jcnt_q != 16'hFFFF) jcnt_d = jcnt_q + 16'd1;
          if (next_q != 28'h0) begin
            visit_d = visit_q | next_q;
            if ((visit_q & next_q) == 28'h0) vcnt_d = vcnt_q + 5'd1;
            pos_r_d = tgt_r_q;
            pos_c_d = tgt_c_q;
            state_d = S_READY;
          end else begin
            state_d = S_FALLEN;
          end
        end
        S_FALLEN: begin
          if (e_respawn) begin
            pos_d   = 28'h1;
            next_d  = 28'h1;
            pos_r_d = 3'd0;
            pos_c_d = 3'd0;
            state_d = S_READY;
          end
        end
        default: state_d = S_READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_READY;
      pos_q   <= 28'h1;
      next_q  <= 28'h1;
      jump_q  <= 3'd0;
      visit_q <= 28'h1;
      vcnt_q  <= 5'd1;
      jcnt_q  <= 16'd0;
      err_q   <= 1'b0;
      pos_r_q <= 3'd0;
      pos_c_q <= 3'd0;
      tgt_r_q <= 3'd0;
      tgt_c_q <= 3'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      next_q  <= next_d;
      jump_q  <= jump_d;
      visit_q <= visit_d;
      vcnt_q  <= vcnt_d;
      jcnt_q  <= jcnt_d;
      err_q   <= err_d;
      pos_r_q <= pos_r_d;
      pos_c_q <= pos_c_d;
      tgt_r_q <= tgt_r_d;
      tgt_c_q <= tgt_c_d;
      tmo_q   <= tmo_d;
    end
  end

  assign position_qb = pos_q;
  assign e_next_qb   = next_q;
  assign e_jump_qb   = jump_q;
  assign cube_visit  = visit_q;
  assign visit_cnt   = vcnt_q;
  assign all_visited = (vcnt_q == 5'd28);
  assign jump_cnt    = jcnt_q;
  assign jump_err    = err_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Directed and randomized bench for qbert_move_ctrl against a (row, col) pyramid model.
module tb_qbert_move_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset, e_dir_valid, done_move_qb, e_respawn, e_restart;
  logic [2:0]  e_dir;
  logic [27:0] position_qb, e_next_qb, cube_visit;
  logic [2:0]  e_jump_qb;
  logic [4:0]  visit_cnt;
  logic        all_visited, jump_err;
  logic [15:0] jump_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: player coordinates, on-pyramid flag, visited set, jump count.
  int          m_r, m_c, m_jumps;
  bit          m_on;
  logic [27:0] m_visit;

  always #5 clk = ~clk;

  qbert_move_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .e_dir_valid(e_dir_valid), .e_dir(e_dir),
    .done_move_qb(done_move_qb), .e_respawn(e_respawn), .e_restart(e_restart),
    .position_qb(position_qb), .e_next_qb(e_next_qb), .e_jump_qb(e_jump_qb),
    .cube_visit(cube_visit), .visit_cnt(visit_cnt), .all_visited(all_visited),
    .jump_cnt(jump_cnt), .jump_err(jump_err)
  );

  function automatic logic [27:0] cube_oh(input int r, input int c);
    if (r < 0 || r > 6 || c < 0 || c > r) return 28'h0;
    return 28'h1 << (r * (r + 1) / 2 + c);
  endfunction

  function automatic void move_rc(input int dir, input int r, input int c,
                                  output int nr, output int nc);
    nr = r;
    nc = c;
    case (dir)
      1: nr = r + 1;
      2: begin nr = r + 1; nc = c + 1; end
      3: begin nr = r - 1; nc = c - 1; end
      4: nr = r - 1;
      default: ;
    endcase
  endfunction

  function automatic int popc(input logic [27:0] v);
    return $countones(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_r = 0; m_c = 0; m_on = 1'b1; m_visit = 28'h1; m_jumps = 0;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_pos"},   position_qb, 32'h1);
    chk({p, "_next"},  e_next_qb,   32'h1);
    chk({p, "_jump"},  e_jump_qb,   32'h0);
    chk({p, "_visit"}, cube_visit,  32'h1);
    chk({p, "_vcnt"},  visit_cnt,   32'd1);
    chk({p, "_allv"},  all_visited, 32'd0);
    chk({p, "_jcnt"},  jump_cnt,    32'd0);
    chk({p, "_err"},   jump_err,    32'd0);
  endtask

  task automatic do_jump(input int dir, input int acc_dly, input int mv_dly);
    int nr, nc;
    logic [27:0] tgt, old;
    move_rc(dir, m_r, m_c, nr, nc);
    tgt = cube_oh(nr, nc);
    old = cube_oh(m_r, m_c);
    done_move_qb = 1'b1; e_dir = 3'(dir); e_dir_valid = 1'b1;
    step();
    e_dir_valid = 1'b0;
    chk("issue_next", e_next_qb, tgt);
    chk("issue_jump", e_jump_qb, dir);
    repeat (acc_dly) step();
    done_move_qb = 1'b0;
    step();
    chk("accept_jump", e_jump_qb, 0);
    chk("accept_next", e_next_qb, tgt);
    repeat (mv_dly) step();
    done_move_qb = 1'b1;
    step();
    chk("commit_lat", position_qb, old);
    step();
    if (tgt != 28'h0) begin
      m_r = nr; m_c = nc; m_visit = m_visit | tgt;
    end else begin
      m_on = 1'b0;
    end
    if (m_jumps < 65535) m_jumps++;
    chk("pos", position_qb, tgt);
    chk("next_idle", e_next_qb, tgt);
    chk("jump_idle", e_jump_qb, 0);
    chk("visit", cube_visit, m_visit);
    chk("vcnt", visit_cnt, popc(m_visit));
    chk("allv", all_visited, popc(m_visit) == 28);
    chk("jcnt", jump_cnt, m_jumps);
  endtask

  task automatic do_respawn();
    e_respawn = 1'b1;
    step();
    e_respawn = 1'b0;
    m_r = 0; m_c = 0; m_on = 1'b1;
    chk("respawn_pos", position_qb, 32'h1);
    chk("respawn_next", e_next_qb, 32'h1);
  endtask

  initial begin
    int d, nr, nc;
    reset = 1'b0; e_dir_valid = 1'b0; e_dir = 3'd0; done_move_qb = 1'b1;
    e_respawn = 1'b0; e_restart = 1'b0;
    model_reset();
    #12;
    chk_reset_vals("rst");
    @(negedge clk) reset = 1'b1;
    step();

    // Down-right from reset, then up-right off the right edge.
    do_jump(1, 1, 1);
    do_jump(3, 0, 0);
    chk("fallen_pos", position_qb, 0);
    e_dir = 3'b001; e_dir_valid = 1'b1;
    step();
    e_dir_valid = 1'b0;
    step();
    chk("fallen_strobe_jump", e_jump_qb, 0);
    chk("fallen_strobe_next", e_next_qb, 0);
    do_respawn();

    // Invalid codes and strobes while the sprite is busy are ignored.
    e_dir = 3'b111; e_dir_valid = 1'b1;
    step();
    chk("bad_code_jump", e_jump_qb, 0);
    e_dir = 3'b000;
    step();
    chk("zero_code_next", e_next_qb, 32'h1);
    e_dir = 3'b001; done_move_qb = 1'b0;
    step();
    e_dir_valid = 1'b0;
    chk("busy_strobe_jump", e_jump_qb, 0);
    done_move_qb = 1'b1;
    step();
    chk("busy_strobe_next", e_next_qb, 32'h1);

    // Timeout: sprite never accepts.
    e_dir = 3'b001; e_dir_valid = 1'b1;
    step();
    e_dir_valid = 1'b0;
    chk("tmo_issue", e_jump_qb, 1);
    for (int i = 1; i < TMO; i++) begin
      step();
      chk("tmo_no_err", jump_err, 0);
    end
    step();
    chk("tmo_err", jump_err, 1);
    chk("tmo_next", e_next_qb, 32'h1);
    chk("tmo_jump", e_jump_qb, 0);
    step();
    chk("tmo_err_pulse", jump_err, 0);
    chk("tmo_jcnt", jump_cnt, m_jumps);

    // Bottom-row fall from bit 21.
    repeat (6) do_jump(1, 0, 1);
    chk("bottom_pos", position_qb, 32'h0020_0000);
    do_jump(2, 1, 0);
    chk("bottom_fall", position_qb, 0);
    do_respawn();

    // Random walk on the pyramid until every cube has been visited.
    for (int k = 0; k < 3000 && popc(m_visit) != 28; k++) begin
      d = int'($urandom_range(4, 1));
      move_rc(d, m_r, m_c, nr, nc);
      if (cube_oh(nr, nc) == 28'h0) continue;
      do_jump(d, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
    end
    chk("cover_vcnt", visit_cnt, 28);
    chk("cover_allv", all_visited, 1);
    d = (m_r == 6) ? 4 : 1;
    do_jump(d, 0, 0);
    chk("revisit_vcnt", visit_cnt, 28);
    do_respawn();

    // Restart beats a simultaneous valid strobe.
    done_move_qb = 1'b1; e_dir = 3'b001; e_dir_valid = 1'b1; e_restart = 1'b1;
    step();
    e_dir_valid = 1'b0; e_restart = 1'b0;
    model_reset();
    chk_reset_vals("restart");
    step();
    chk("restart_nojump", e_jump_qb, 0);

    // Asynchronous reset while MOVING.
    e_dir = 3'b010; e_dir_valid = 1'b1;
    step();
    e_dir_valid = 1'b0;
    chk("mid_issue", e_next_qb, 32'h4);
    done_move_qb = 1'b0;
    step();
    chk("mid_moving", e_jump_qb, 0);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk) reset = 1'b1;
    done_move_qb = 1'b1;
    step();
    chk("post_reset_pos", position_qb, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
